// File: rtl/fir_tdm_sequencer.sv
// fir_tdm_sequencer: round-robin time-multiplexed FIR sharing one signed MAC across channels
module fir_tdm_sequencer #(
  parameter int N_CH = 4,
  parameter int INPUT_WORD_SIZE = 16,
  parameter int COEFF_WORD_SIZE = 16,
  parameter int N_COEFFS = 5,
  localparam int OUTPUT_WORD_SIZE = INPUT_WORD_SIZE + COEFF_WORD_SIZE + $clog2(N_COEFFS),
  localparam int KW = $clog2(N_COEFFS),
  localparam int CW = $clog2(N_CH)
) (
  input  logic clk,
  input  logic rst,
  input  logic [N_CH*INPUT_WORD_SIZE-1:0] s_data,
  input  logic [N_CH-1:0] s_valid,
  output logic [N_CH-1:0] s_ready,
  input  logic coeff_wr_en,
  input  logic [KW-1:0] coeff_wr_addr,
  input  logic [COEFF_WORD_SIZE-1:0] coeff_wr_data,
  output logic coeff_wr_ready,
  output logic [OUTPUT_WORD_SIZE-1:0] m_data,
  output logic [CW-1:0] m_channel,
  output logic m_valid,
  input  logic m_ready,
  output logic busy
);
  localparam int IW = INPUT_WORD_SIZE;
  localparam int PW = INPUT_WORD_SIZE + COEFF_WORD_SIZE;
  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;
  state_t state, state_nx;
  logic signed [IW-1:0] x [N_CH][N_COEFFS];
  logic signed [COEFF_WORD_SIZE-1:0] cf [N_COEFFS];
  logic signed [OUTPUT_WORD_SIZE-1:0] acc;
  logic signed [PW-1:0] prod;
  logic [CW-1:0] rr, g, gnt;
  logic [KW-1:0] k;
  logic any, gnt_ok;
  always_comb begin
    gnt = rr;
    any = 1'b0;
    for (int i = N_CH; i >= 1; i--) begin
      logic [CW-1:0] idx;
      idx = CW'((int'(rr) + i) % N_CH);
      if (s_valid[idx]) begin
        gnt = idx;
        any = 1'b1;
      end
    end
  end
  assign gnt_ok = state == IDLE && !coeff_wr_en && any;
  assign s_ready = gnt_ok ? N_CH'(1) << gnt : '0;
  assign coeff_wr_ready = state == IDLE;
  assign busy = state != IDLE;
  assign m_valid = state == OUT;
  assign m_data = acc;
  assign m_channel = g;
  assign prod = x[g][k] * cf[k];
  always_comb begin
    state_nx = state;
    state_nx = state == IDLE ? (gnt_ok ? MAC : IDLE) :
               state == MAC ? (k == KW'(N_COEFFS - 1) ? OUT : MAC) :
               (m_ready ? IDLE : OUT);
  end
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk)
    if (rst) begin
      rr <= CW'(N_CH - 1);
      g <= '0;
      k <= '0;
      acc <= '0;
      for (int i = 0; i < N_CH; i++)
        for (int j = 0; j < N_COEFFS; j++) x[i][j] <= '0;
      for (int j = 0; j < N_COEFFS; j++) cf[j] <= '0;
    end else begin
      if (state == IDLE && coeff_wr_en && 32'(coeff_wr_addr) < N_COEFFS) cf[coeff_wr_addr] <= coeff_wr_data;
      if (gnt_ok) begin
        for (int j = N_COEFFS - 1; j > 0; j--) x[gnt][j] <= x[gnt][j-1];
        x[gnt][0] <= s_data[gnt*IW +: IW];
        acc <= '0;
        k <= '0;
        g <= gnt;
      end
      if (state == MAC) begin
        acc <= acc + {{KW{prod[PW-1]}}, prod};
        k <= k + 1'b1;
      end
      if (state == OUT && m_ready) rr <= g;
    end
endmodule

// File: tb/tb_fir_tdm_sequencer.sv
// tb_fir_tdm_sequencer: directed self-checking bench for fir_tdm_sequencer
module tb_fir_tdm_sequencer;
  logic clk = 0, rst = 1;
  logic [63:0] s_data = '0;
  logic [3:0] s_valid = '0, s_ready;
  logic coeff_wr_en = 0, coeff_wr_ready;
  logic [2:0] coeff_wr_addr = '0;
  logic [15:0] coeff_wr_data = '0;
  logic [34:0] m_data;
  logic [1:0] m_channel;
  logic m_valid, m_ready = 1, busy;
  int n_vec = 0, n_err = 0;
  fir_tdm_sequencer dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .coeff_wr_en(coeff_wr_en), .coeff_wr_addr(coeff_wr_addr), .coeff_wr_data(coeff_wr_data),
    .coeff_wr_ready(coeff_wr_ready), .m_data(m_data), .m_channel(m_channel),
    .m_valid(m_valid), .m_ready(m_ready), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input longint unsigned got, input longint unsigned exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask
  task automatic wr(input int a, input logic [15:0] d);
    int w = 0;
    coeff_wr_en = 1;
    coeff_wr_addr = 3'(a);
    coeff_wr_data = d;
    #1;
    while (!coeff_wr_ready && w < 20) begin cyc(); w++; end
    chk("wr_ready", coeff_wr_ready, 1);
    cyc();
    coeff_wr_en = 0;
  endtask
  task automatic go(input int ch, input logic [15:0] d, output int lat);
    int w = 0;
    s_data[ch*16 +: 16] = d;
    s_valid = 4'b0001 << ch;
    #1;
    while (!s_ready[ch] && w < 20) begin cyc(); #1; w++; end
    chk("grant", s_ready[ch], 1);
    cyc();
    s_valid = '0;
    lat = 1;
    while (!m_valid && lat < 20) begin cyc(); lat++; end
  endtask
  task automatic smp(input string tag, input int ch, input logic [15:0] d, input longint unsigned exp);
    int lat;
    go(ch, d, lat);
    chk({tag, "_valid"}, m_valid, 1);
    chk({tag, "_data"}, m_data, exp);
    chk({tag, "_ch"}, m_channel, ch);
    cyc();
  endtask
  initial begin
    int gch[8], gt[8], och[8];
    int ng, no, lat, bad, hits;
    logic [34:0] d0;
    repeat (3) cyc();
    rst = 0;
    chk("rst_s_ready", s_ready, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_m_channel", m_channel, 0);
    chk("rst_busy", busy, 0);
    chk("rst_wr_ready", coeff_wr_ready, 1);
    s_valid = 4'hF;
    ng = 0;
    no = 0;
    for (int t = 0; t < 60 && no < 5; t++) begin
      #1;
      if (|s_ready && ng < 8) begin
        for (int i = 0; i < 4; i++) if (s_ready[i]) gch[ng] = i;
        gt[ng] = t;
        ng++;
      end
      if (m_valid) begin och[no] = m_channel; no++; end
      cyc();
    end
    s_valid = '0;
    chk("rr_outputs", no, 5);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("rr_grant%0d", i), gch[i], i % 4);
      chk($sformatf("rr_out%0d", i), och[i], i % 4);
      if (i > 0) chk($sformatf("rr_gap%0d", i), gt[i] - gt[i-1], 7);
    end
    for (int i = 0; i < 5; i++) wr(i, 16'(i + 1));
    go(1, 16'd1, lat);
    chk("imp_latency", lat, 6);
    chk("imp0_data", m_data, 1);
    chk("imp0_ch", m_channel, 1);
    cyc();
    for (int i = 1; i < 6; i++) smp($sformatf("imp%0d", i), 1, 16'd0, i < 5 ? i + 1 : 0);
    m_ready = 0;
    go(2, 16'd7, lat);
    d0 = m_data;
    chk("bp_data", d0, 7);
    chk("bp_ch", m_channel, 2);
    bad = 0;
    s_valid = 4'hF;
    coeff_wr_en = 1;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (!m_valid || m_data != d0 || m_channel != 2 || s_ready != 0 || coeff_wr_ready) bad++;
      cyc();
    end
    s_valid = '0;
    coeff_wr_en = 0;
    chk("bp_stable", bad, 0);
    m_ready = 1;
    cyc();
    chk("bp_idle", busy, 0);
    chk("bp_mvalid", m_valid, 0);
    for (int i = 0; i < 5; i++) wr(i, 16'h8000);
    m_ready = 0;
    go(3, 16'd0, lat);
    coeff_wr_en = 1;
    coeff_wr_addr = 3'd0;
    coeff_wr_data = 16'd1;
    #1;
    chk("busy_wr_ready", coeff_wr_ready, 0);
    cyc();
    cyc();
    coeff_wr_en = 0;
    m_ready = 1;
    cyc();
    for (int i = 1; i <= 5; i++) smp($sformatf("ext%0d", i), 0, 16'h8000, longint'(i) << 30);
    s_data[16 +: 16] = 16'd100;
    s_valid = 4'b0010;
    #1;
    chk("mid_grant", s_ready, 4'b0010);
    cyc();
    s_valid = '0;
    cyc();
    cyc();
    rst = 1;
    cyc();
    rst = 0;
    hits = 0;
    for (int i = 0; i < 10; i++) begin
      if (m_valid) hits++;
      cyc();
    end
    chk("mid_no_valid", hits, 0);
    chk("mid_busy", busy, 0);
    chk("mid_m_data", m_data, 0);
    for (int i = 0; i < 5; i++) wr(i, 16'(i + 1));
    smp("clr0", 0, 16'd1, 1);
    smp("clr1", 0, 16'd0, 2);
    smp("clr_ch1", 1, 16'd1, 1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/fir_tdm_sequencer.md
# fir_tdm_sequencer

Time-multiplexed FIR engine and scheduler for the interpolator chain. A single signed multiply-accumulate unit is shared between N_CH independent sample channels. Round-robin arbitration picks a channel, one tap is evaluated per cycle, and the result is presented on a valid/ready output. Each channel keeps its own delay line; all channels share one runtime-writable coefficient set.

## Interface
- N_CH, 4: number of input channels; must be at least 2.
- INPUT_WORD_SIZE, 16: signed sample width.
- COEFF_WORD_SIZE, 16: signed coefficient width.
- N_COEFFS, 5: taps per channel; must be at least 2.
- OUTPUT_WORD_SIZE, localparam: INPUT_WORD_SIZE + COEFF_WORD_SIZE + $clog2(N_COEFFS).
- clk  in  1  the single clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- s_data  in  N_CH*INPUT_WORD_SIZE  per-channel signed samples; channel c occupies bits [c*INPUT_WORD_SIZE +: INPUT_WORD_SIZE].
- s_valid  in  N_CH  per-channel sample valid.
- s_ready  out  N_CH  per-channel accept; at most one bit is high in any cycle.
- coeff_wr_en  in  1  coefficient write strobe.
- coeff_wr_addr  in  $clog2(N_COEFFS)  tap index to write.
- coeff_wr_data  in  COEFF_WORD_SIZE  signed coefficient value.
- coeff_wr_ready  out  1  high only in IDLE; a write is accepted when coeff_wr_en and coeff_wr_ready are both high.
- m_data  out  OUTPUT_WORD_SIZE  signed filter result.
- m_channel  out  $clog2(N_CH)  channel that m_data belongs to.
- m_valid  out  1  result valid.
- m_ready  in  1  downstream accept.
- busy  out  1  high whenever state is not IDLE.

## Operation
- Storage:
  - Per-channel delay line x[c][0..N_COEFFS-1]; x[c][0] holds the newest sample.
  - Coefficient register c[0..N_COEFFS-1].
  - Accumulator acc, OUTPUT_WORD_SIZE bits wide.
  - Round-robin pointer rr, holding the last served channel.
- State machine: IDLE, MAC, OUT.
- IDLE:
  - A coefficient write has priority. On an accepted write, c[coeff_wr_addr] is updated, no channel is granted that cycle, and all s_ready bits stay low.
  - An address of N_COEFFS or above is ignored, but the cycle is still consumed.
  - Otherwise, if any s_valid is high, grant the first valid channel searching rr+1, rr+2, … modulo N_CH.
  - For the granted channel g: drive s_ready[g]=1 for exactly this cycle, shift x[g] by one (discarding the oldest sample), load s_data[g] into x[g][0], clear acc, set tap counter k=0, record g, and go to MAC.
- MAC:
  - Each cycle, acc += sext(x[g][k]) * sext(c[k]), then k++.
  - After k = N_COEFFS-1, go to OUT.
  - The multiply is full-precision signed; results are sign-extended into OUTPUT_WORD_SIZE; no rounding and no saturation.
- OUT:
  - m_valid=1, m_data=acc, m_channel=g.
  - These outputs hold stable until m_ready=1.
  - On the m_ready cycle: rr←g and go to IDLE.
- Coefficient writes presented while busy are not accepted; the writer must hold the strobe until coeff_wr_ready is high.
- s_valid on channels that are not granted is not consumed; those channels hold their data.
- Reset sets:
  - state=IDLE, rr=N_CH-1 (so channel 0 wins first), acc=0.
  - All delay lines and coefficients to 0.
  - Outputs: s_ready=0, coeff_wr_ready=1 in the first cycle after reset, m_valid=0, m_data=0, m_channel=0, busy=0.
- A reset asserted mid-MAC or mid-OUT aborts the operation. The partial result is never emitted.

## Timing
- Grant in IDLE at cycle T. MAC occupies cycles T+1 through T+N_COEFFS. m_valid first rises at T+N_COEFFS+1.
- Peak throughput with m_ready held high: one sample per N_COEFFS+2 cycles (IDLE, N_COEFFS MAC cycles, OUT).
- s_ready is a registered-state decode. It is asserted combinationally only in the IDLE grant cycle and depends on s_valid in that same cycle.
- m_valid never falls without a handshake. m_data and m_channel never change while m_valid=1 and m_ready=0.
- A coefficient written in IDLE at cycle T applies to any grant from T+1 onward.
- Fairness: with all channels continuously valid, every channel is served exactly once per N_CH grants.

## Test plan
- Reset: hold rst for 3 cycles → s_ready=0, m_valid=0, m_data=0, busy=0, coeff_wr_ready=1; the first grant with all s_valid high goes to channel 0.
- Impulse response: write c=[1,2,3,4,5]; on channel 1 send 1 followed by zeros → m_data sequence 1,2,3,4,5,0 with m_channel=1; first m_valid exactly 6 cycles after the grant.
- Round-robin: hold s_valid=4'b1111 with m_ready high → m_channel order 0,1,2,3,0; grants are spaced 7 cycles apart.
- Backpressure: hold m_ready low for 10 cycles in OUT → m_valid, m_data and m_channel stay stable, s_ready stays 0, coeff_wr_ready stays 0; after m_ready goes high, IDLE follows on the next cycle.
- Extremes: all coefficients -32768, channel 0 fed -32768 for 5 samples → m_data = 5·2^30 = 5368709120 with no wrap in 35 bits; coefficient write attempted while busy is not accepted.
- Reset mid-MAC: assert rst during the 3rd MAC cycle → no m_valid; all delay lines read back as zero (the next impulse produces a clean response).
